// File: rtl/rand_pkg.sv
// Shared definitions for the random-word arbiter: LFSR geometry, reset seed,
// FSM state encoding and the 16-bit generator's next-state function.
package rand_pkg;

  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'h800D;

  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_SERVE  = 1'b1
  } state_e;

  // Shift right with a 4-tap feedback into the MSB; bits 10..12 are then
  // overwritten from the old LSB so the sequence matches the team generator.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] d);
    logic [LFSR_WIDTH-1:0] n;
    n     = {d[15] ^ d[13] ^ d[12] ^ d[10], d[15:1]};
    n[10] = d[0] ^ d[11];
    n[11] = d[0] ^ d[13];
    n[12] = d[0] ^ d[14];
    return n;
  endfunction

endpackage

// File: rtl/rand_lfsr16_en.sv
// 16-bit LFSR with step enable and synchronous load; a zero load value is
// replaced by the default seed so the register can never lock up at zero.
module rand_lfsr16_en
  import rand_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  en,
  input  logic                  load,
  input  logic [LFSR_WIDTH-1:0] load_value,
  output logic [LFSR_WIDTH-1:0] data
);

  logic [LFSR_WIDTH-1:0] data_q;
  logic [LFSR_WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = (load_value == '0) ? LFSR_SEED : load_value;
    end else if (en) begin
      data_d = lfsr_step(data_q);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      data_q <= LFSR_SEED;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/rand_arbiter.sv
// Round-robin arbiter handing out distinct LFSR words to NUM_REQ requesters,
// with a configurable warm-up run of free LFSR steps after reset or reseed.
module rand_arbiter
  import rand_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WARMUP  = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    gnt,
  output logic                  rand_valid,
  output logic [LFSR_WIDTH-1:0] rand_data,
  output logic [ID_W-1:0]       rand_id,
  output logic                  ready
);

  localparam logic [7:0] WARMUP_CNT = 8'(WARMUP);

  state_e                state_q;
  logic [7:0]            cnt_q;
  logic [ID_W-1:0]       ptr_q;
  logic [ID_W-1:0]       ptr_d;
  logic                  rand_valid_q;
  logic [LFSR_WIDTH-1:0] rand_data_q;
  logic [ID_W-1:0]       rand_id_q;
  logic                  ready_q;

  logic [LFSR_WIDTH-1:0] lfsr_data;
  logic                  lfsr_en;
  logic                  hit;
  logic [ID_W-1:0]       gidx;
  logic [ID_W:0]         sum;
  logic                  xfer;

  // Search from the pointer with wrap-around; a reseed cycle never grants.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    sum  = '0;
    gnt  = '0;
    if (state_q == ST_SERVE && !seed_load) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, ptr_q} + (ID_W+1)'(k);
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
          sum = sum - (ID_W+1)'(NUM_REQ);
        end
        if (!hit && req[sum[ID_W-1:0]]) begin
          hit  = 1'b1;
          gidx = sum[ID_W-1:0];
        end
      end
      if (hit) begin
        gnt[gidx] = 1'b1;
      end
    end
  end

  assign xfer    = |(req & gnt);
  assign ptr_d   = (gidx == ID_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  assign lfsr_en = ((state_q == ST_WARMUP) && (cnt_q != 8'd0)) || xfer;

  rand_lfsr16_en u_lfsr (
    .clock      (clock),
    .resetn     (resetn),
    .en         (lfsr_en),
    .load       (seed_load),
    .load_value (seed),
    .data       (lfsr_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_WARMUP;
      cnt_q        <= WARMUP_CNT;
      ptr_q        <= '0;
      rand_valid_q <= 1'b0;
      rand_data_q  <= '0;
      rand_id_q    <= '0;
      ready_q      <= 1'b0;
    end else begin
      rand_valid_q <= xfer;
      if (xfer) begin
        rand_data_q <= lfsr_data;
        rand_id_q   <= gidx;
        ptr_q       <= ptr_d;
      end
      if (seed_load) begin
        state_q <= ST_WARMUP;
        cnt_q   <= WARMUP_CNT;
        ready_q <= 1'b0;
      end else begin
        case (state_q)
          // A zero count means no free steps remain: go straight to serving.
          ST_WARMUP: begin
            if (cnt_q == 8'd0) begin
              state_q <= ST_SERVE;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) begin
                state_q <= ST_SERVE;
                ready_q <= 1'b1;
              end
            end
          end
          ST_SERVE: begin
            ready_q <= 1'b1;
          end
          default: begin
            state_q <= ST_WARMUP;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rand_valid = rand_valid_q;
  assign rand_data  = rand_data_q;
  assign rand_id    = rand_id_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_rand_arbiter.sv
// Bench for rand_arbiter: two instances (no warm-up and 16-step warm-up) share
// stimulus and are compared every cycle against a transaction-level model.
module tb_rand_arbiter;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        seed_load;
  logic [15:0] seed;
  logic [3:0]  req;

  logic [3:0]  gnt_a, gnt_b;
  logic        vld_a, vld_b;
  logic [15:0] data_a, data_b;
  logic [1:0]  id_a, id_b;
  logic        rdy_a, rdy_b;

  always #5 clock = ~clock;

  rand_arbiter #(.NUM_REQ(4), .WARMUP(0)) u_w0 (
    .clock(clock), .resetn(resetn), .seed_load(seed_load), .seed(seed), .req(req),
    .gnt(gnt_a), .rand_valid(vld_a), .rand_data(data_a), .rand_id(id_a), .ready(rdy_a)
  );

  rand_arbiter #(.NUM_REQ(4), .WARMUP(16)) u_w16 (
    .clock(clock), .resetn(resetn), .seed_load(seed_load), .seed(seed), .req(req),
    .gnt(gnt_b), .rand_valid(vld_b), .rand_data(data_b), .rand_id(id_b), .ready(rdy_b)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] obs_gnt_a, obs_gnt_b;

  // Reference model: per instance, remaining warm-up steps, serving flag,
  // current generator word, round-robin pointer and the last published word.
  int          m_warm [2];
  bit          m_srv  [2];
  logic [15:0] m_lfsr [2];
  int          m_ptr  [2];
  bit          m_vld  [2];
  logic [15:0] m_data [2];
  int          m_id   [2];

  function automatic int wparam(input int k);
    return (k == 0) ? 0 : 16;
  endfunction

  function automatic logic [15:0] ref_next(input logic [15:0] d);
    logic [15:0] n;
    n     = d >> 1;
    n[15] = d[15] ^ d[13] ^ d[12] ^ d[10];
    n[10] = d[0] ^ d[11];
    n[11] = d[0] ^ d[13];
    n[12] = d[0] ^ d[14];
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_warm[k] = wparam(k);
      m_srv[k]  = 1'b0;
      m_lfsr[k] = 16'h800D;
      m_ptr[k]  = 0;
      m_vld[k]  = 1'b0;
      m_data[k] = 16'h0000;
      m_id[k]   = 0;
    end
  endtask

  function automatic int pick(input int k, input logic [3:0] r, input logic sl);
    int i;
    if (!m_srv[k] || sl) return -1;
    for (int j = 0; j < N; j++) begin
      i = (m_ptr[k] + j) % N;
      if (r[2'(i)]) return i;
    end
    return -1;
  endfunction

  task automatic check_inst(input int k, input int e);
    string       p;
    logic [3:0]  g;
    logic        v, rd;
    logic [15:0] d;
    logic [1:0]  id;
    logic [3:0]  eg;
    p  = (k == 0) ? "w0" : "w16";
    g  = (k == 0) ? gnt_a  : gnt_b;
    v  = (k == 0) ? vld_a  : vld_b;
    d  = (k == 0) ? data_a : data_b;
    id = (k == 0) ? id_a   : id_b;
    rd = (k == 0) ? rdy_a  : rdy_b;
    eg = (e < 0) ? 4'b0000 : (4'b0001 << e);
    chk({p, "_gnt"},   32'(g),  32'(eg));
    chk({p, "_ready"}, 32'(rd), 32'(m_srv[k]));
    chk({p, "_valid"}, 32'(v),  32'(m_vld[k]));
    chk({p, "_data"},  32'(d),  32'(m_data[k]));
    chk({p, "_id"},    32'(id), 32'(m_id[k]));
  endtask

  task automatic model_update(input int k, input int e);
    if (e >= 0) begin
      m_vld[k]  = 1'b1;
      m_data[k] = m_lfsr[k];
      m_id[k]   = e;
      m_lfsr[k] = ref_next(m_lfsr[k]);
      m_ptr[k]  = (e + 1) % N;
    end else begin
      m_vld[k] = 1'b0;
    end
    if (seed_load) begin
      m_lfsr[k] = (seed == 16'h0000) ? 16'h800D : seed;
      m_srv[k]  = 1'b0;
      m_warm[k] = wparam(k);
    end else if (!m_srv[k]) begin
      if (m_warm[k] == 0) begin
        m_srv[k] = 1'b1;
      end else begin
        m_lfsr[k] = ref_next(m_lfsr[k]);
        m_warm[k]--;
        if (m_warm[k] == 0) m_srv[k] = 1'b1;
      end
    end
  endtask

  // Entered and left at posedge+1: drive, settle, check, advance model, clock.
  task automatic cycle(input logic [3:0] r, input logic sl, input logic [15:0] sd);
    int e0, e1;
    req       = r;
    seed_load = sl;
    seed      = sd;
    #2;
    obs_gnt_a = gnt_a;
    obs_gnt_b = gnt_b;
    e0 = pick(0, r, sl);
    e1 = pick(1, r, sl);
    check_inst(0, e0);
    check_inst(1, e1);
    model_update(0, e0);
    model_update(1, e1);
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_inst(0, -1);
    check_inst(1, -1);
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  initial begin : main
    logic [15:0] ref17;
    int          nz;
    bit          done;

    resetn    = 1'b0;
    req       = 4'b0000;
    seed_load = 1'b0;
    seed      = 16'h0000;
    repeat (2) @(posedge clock);
    #1;
    model_reset();
    check_inst(0, -1);
    check_inst(1, -1);
    resetn = 1'b1;

    // Lone requester granted back-to-back from the reset seed.
    cycle(4'b0001, 1'b0, 16'h0);
    cycle(4'b0001, 1'b0, 16'h0);
    chk("r029_gnt_first", 32'(obs_gnt_a), 32'h1);
    chk("r029_data_first", 32'(data_a), 32'h800D);
    cycle(4'b0001, 1'b0, 16'h0);
    chk("r029_gnt_second", 32'(obs_gnt_a), 32'h1);
    chk("r029_data_second", 32'(data_a), 32'hDC06);
    chk("r029_id_second", 32'(id_a), 32'h0);

    // All four requesting: strict rotation.
    pulse_reset();
    cycle(4'b1111, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b0, 16'h0);
      chk("r030_order", 32'(obs_gnt_a), 32'(4'b0001 << (i % 4)));
    end

    // Warm-up length and first word of the 16-step instance.
    pulse_reset();
    ref17 = 16'h800D;
    repeat (16) ref17 = ref_next(ref17);
    nz   = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      cycle(4'b1111, 1'b0, 16'h0);
      if (obs_gnt_b != 4'b0000) done = 1'b1;
      else nz++;
    end
    chk("r031_warm_cycles", 32'(nz), 32'd16);
    chk("r031_first_word", 32'(data_b), 32'(ref17));

    // Zero seed reload suppresses the grant and restarts at the default seed.
    cycle(4'b0010, 1'b1, 16'h0000);
    chk("r032_no_grant", 32'(obs_gnt_a), 32'h0);
    cycle(4'b0010, 1'b0, 16'h0);
    cycle(4'b0010, 1'b0, 16'h0);
    chk("r032_data", 32'(data_a), 32'h800D);
    chk("r032_id", 32'(id_a), 32'h1);

    // Reset mid-stream.
    repeat (3) cycle(4'b0100, 1'b0, 16'h0);
    pulse_reset();
    cycle(4'b0100, 1'b0, 16'h0);
    cycle(4'b0100, 1'b0, 16'h0);
    chk("r033_data", 32'(data_a), 32'h800D);
    chk("r033_id", 32'(id_a), 32'h2);

    // Alternating 1001 / 0000.
    pulse_reset();
    cycle(4'b0000, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) begin
      cycle((i % 2 == 0) ? 4'b1001 : 4'b0000, 1'b0, 16'h0);
      if (i % 2 == 0)
        chk("r034_alt", 32'(obs_gnt_a), (i % 4 == 0) ? 32'h1 : 32'h8);
    end

    // Randomised traffic with occasional reseeds and resets.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset();
      end else begin
        cycle(4'($urandom_range(0, 15)),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rand_arbiter.md
RAND_ARBITER -- requirements
Module: rand_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing the random source (2..8).
REQ-002 Parameter WARMUP, default 16, is the number of free LFSR steps taken after reset or seed load before serving (0..255).
REQ-003 Port clock  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port resetn  input  1  is the asynchronous, active-low reset.
REQ-005 Port seed_load  input  1  requests reload of the LFSR from seed.
REQ-006 Port seed  input  16  is the seed value, sampled when seed_load=1.
REQ-007 Port req  input  NUM_REQ  carries per-requester word requests, one bit per requester.
REQ-008 Port gnt  output  NUM_REQ  is a one-hot-or-zero, combinational grant; a transfer occurs when req[i] and gnt[i] are both 1.
REQ-009 Port rand_valid  output  1  is high for one cycle when rand_data holds a granted word.
REQ-010 Port rand_data  output  16  is the random word for the preceding cycle's transfer.
REQ-011 Port rand_id  output  clog2(NUM_REQ)  is the index of the requester that owns rand_data.
REQ-012 Port ready  output  1  is high in SERVE state only.

Function
REQ-013 The internal LFSR next state from d SHALL be: {d15^d13^d12^d10, d[15:1]}, then bit10 = d0^d11, bit11 = d0^d13, bit12 = d0^d14 (old d values) -- identical to the team's 16-bit generator.
REQ-014 The FSM SHALL have states WARMUP and SERVE.
REQ-015 In WARMUP the LFSR SHALL step every cycle while a down-counter decrements from WARMUP, with gnt=0 and ready=0.
REQ-016 WARMUP SHALL go to SERVE on the cycle the counter reaches 0; with WARMUP=0, SERVE is entered directly.
REQ-017 In SERVE the LFSR SHALL step only on a transfer cycle, so every granted word is distinct in sequence and no word is lost or reused.
REQ-018 Arbitration SHALL be round-robin: search starts at pointer p, grants the first asserted req at index p, p+1, ... (mod NUM_REQ), and sets p to granted index+1 (mod NUM_REQ) after a transfer.
REQ-019 At most one gnt bit SHALL be high per cycle; gnt SHALL be all-zero when req=0 or the state is not SERVE.
REQ-020 On a transfer, the next cycle SHALL present rand_valid=1, rand_data=LFSR value before stepping, and rand_id=granted index (latency 1); otherwise rand_valid=0 and rand_data/rand_id hold.
REQ-021 Back-to-back transfers SHALL be supported every cycle, including repeated grants to a lone requester.
REQ-022 seed_load=1 in any state SHALL load the LFSR with seed (0x800D if seed==0), reload the counter, enter WARMUP, and suppress any grant in that cycle.
REQ-023 A seed_load while rand_valid is due SHALL NOT cancel that already-committed output.
REQ-024 A req deasserted without a grant SHALL be dropped silently; no request is queued.

Reset
REQ-025 resetn=0 SHALL immediately force: LFSR=0x800D, state=WARMUP, counter=WARMUP, p=0, rand_valid=0, rand_data=0, rand_id=0, ready=0; gnt=0 follows combinationally.
REQ-026 Reset assertion mid-transfer SHALL discard the pending output; the first edge after release begins WARMUP.

Structure
REQ-027 Shared package rand_pkg SHALL hold LFSR_WIDTH=16, LFSR_SEED=16'h800D and the state enumeration.
REQ-028 The LFSR SHALL be one sub-module, rand_lfsr16_en (ports: clock, resetn, en, load, load_value, data); arbitration and FSM stay in rand_arbiter.

Verification
REQ-029 WARMUP=0, after reset req=4'b0001 for 2 cycles -> gnt=0001 both cycles; rand_data 0x800D then 0xDC06, rand_id=0.
REQ-030 WARMUP=0, req=4'b1111 held 8 cycles -> gnt order 0,1,2,3,0,1,2,3; rand_id follows one cycle later; eight distinct consecutive LFSR words.
REQ-031 WARMUP=16, req=1111 from reset release -> gnt=0 and ready=0 for exactly 16 cycles; first word equals 17th LFSR state from 0x800D.
REQ-032 WARMUP=0, seed_load=1 with seed=0x0000 and req=0010 in the same cycle -> no grant that cycle; next word served is 0x800D.
REQ-033 WARMUP=0, req=0100 then resetn pulsed low mid-stream -> outputs zero immediately; after release, sequence restarts at 0x800D, pointer at 0.
REQ-034 WARMUP=0, req alternating 1001/0000 -> grants alternate 0,3,0,3; LFSR advances only on grant cycles.
